mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares the single main-memory port between two cache controllers: port 0 is the instruction cache, port 1 is the data cache. Each requester uses the same strobe/ready handshake the cache controllers already drive toward memory. The arbiter forwards one transaction at a time, returns read data and a completion pulse to the owner, and aborts any access that memory does not answer within a bounded number of cycles.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, max cycles MStrobe may wait for MReady before abort (≥2)

- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- CStrobe0 / CStrobe1  in  1  request from port n, level, held until its CReady pulse
- CRW0 / CRW1  in  1  1 = read, 0 = write
- CAddress0 / CAddress1  in  AW  request address
- CWData0 / CWData1  in  DW  write data
- CReady0 / CReady1  out  1  one-cycle completion pulse to port n
- CRData0 / CRData1  out  DW  read data, valid while CReadyn = 1
- CErr0 / CErr1  out  1  high with CReadyn when the access timed out
- MStrobe  out  1  memory request, held until MReady sampled or timeout
- MRW  out  1  1 = read, 0 = write
- MAddress  out  AW  memory address
- MWData  out  DW  memory write data
- MRData  in  DW  memory read data, valid with MReady
- MReady  in  1  memory completion, one-cycle pulse
- Gnt  out  2  one-hot current owner, 00 when idle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: sample CStrobe0/1.
  - None asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port that is not `last`.
  - On grant: latch the owner's CRW/CAddress/CWData into MRW/MAddress/MWData, set MStrobe = 1, set Gnt, clear the wait counter, go to BUSY.
- BUSY: MStrobe held high; owner inputs ignored because they were already latched. The wait counter increments each cycle.
  - MReady = 1: MStrobe ← 0. For a read, capture MRData into the owner's CRData; for a write, the owner's CRData keeps its previous value. Set CReadyn = 1, CErrn = 0, update `last` ← owner, go to DONE.
  - Counter reaches TIMEOUT-1 with MReady = 0: MStrobe ← 0, CRDatan ← 0, CReadyn = 1, CErrn = 1, update `last`, go to DONE.
  - MReady on the same cycle as the timeout: MReady wins and no error is raised.
- DONE: CReadyn, CErrn and Gnt clear. Return to IDLE.
  - The owner deasserts its strobe in the cycle after CReady; IDLE therefore never re-grants a completed request.
- MReady is ignored outside BUSY.
- The non-owner's strobe stays pending. Because of the `last` rotation it is served next, so neither port can starve the other.
- Wait counter width is clog2(TIMEOUT).

## Timing
- Reset (reset = 0, asynchronous) forces:
  - State IDLE, MStrobe = 0, MRW = 1, MAddress = 0, MWData = 0.
  - CReady0/1 = 0, CErr0/1 = 0, CRData0/1 = 0, Gnt = 00.
  - `last` = 1, so port 0 wins the first tie.
- Reset mid-transaction: the transaction is dropped with no CReady pulse, and MStrobe falls immediately.
- All outputs are registered.
- Latency (strobe sampled at edge E):
  - MStrobe is high after E.
  - If MReady is high in the first BUSY cycle, CReady is high after E+1.
  - Minimum strobe-to-CReady is 2 cycles. Total latency is 2 + memory wait cycles.
- Back-to-back: a pending port is granted in the IDLE cycle after DONE. There are 2 cycles of gap between successive MStrobe assertions.
- Timeout: CReady/CErr are high exactly TIMEOUT cycles after MStrobe rose.

## Test plan
- Reset: assert reset = 0 mid-BUSY -> MStrobe = 0, Gnt = 00 and all CReady = 0 immediately; after release, the first tie goes to port 0.
- Single read, port 0: addr 0x0000_1004; memory returns 0xDEAD_BEEF with MReady in the 3rd BUSY cycle -> MRW = 1, MAddress = 0x0000_1004, then CReady0 pulses 1 cycle with CRData0 = 0xDEAD_BEEF, CErr0 = 0, and CReady1 stays 0.
- Single write, port 1: addr 0x0000_2008, data 0x1234_5678 -> MRW = 0, MWData = 0x1234_5678 held until MReady, then CReady1 pulse, CErr1 = 0.
- Simultaneous requests: both strobes high from reset -> Gnt = 01 first, then Gnt = 10. Both re-request -> the order is 01, 10, 01, 10, ..., with no port granted twice in a row while the other is pending.
- Timeout: MReady never asserted, TIMEOUT = 64 -> MStrobe falls, and CReady0 = CErr0 = 1 with CRData0 = 0 exactly 64 cycles after MStrobe rose. The next request proceeds normally.
- MReady on the timeout cycle -> normal completion with CErr = 0 and captured data; a stray MReady while IDLE is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one main-memory port between two cache
// controllers (port 0 = instruction cache, port 1 = data cache). One transaction is forwarded
// at a time; memory accesses that go unanswered for TIMEOUT cycles are aborted with an error.
//
// Ports:
//   clk, reset                   clock and asynchronous active-low reset
//   CStrobe*/CRW*/CAddress*/CWData*  requester n: level request, 1 = read, address, write data
//   CReady*/CRData*/CErr*        requester n: completion pulse, read data, timeout flag
//   MStrobe/MRW/MAddress/MWData  memory request side (all registered)
//   MRData/MReady                memory read data and completion pulse
//   Gnt                          one-hot current owner, 00 when idle
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CStrobe0,
  input  logic          CRW0,
  input  logic [AW-1:0] CAddress0,
  input  logic [DW-1:0] CWData0,
  output logic          CReady0,
  output logic [DW-1:0] CRData0,
  output logic          CErr0,
  input  logic          CStrobe1,
  input  logic          CRW1,
  input  logic [AW-1:0] CAddress1,
  input  logic [DW-1:0] CWData1,
  output logic          CReady1,
  output logic [DW-1:0] CRData1,
  output logic          CErr1,
  output logic          MStrobe,
  output logic          MRW,
  output logic [AW-1:0] MAddress,
  output logic [DW-1:0] MWData,
  input  logic [DW-1:0] MRData,
  input  logic          MReady,
  output logic [1:0]    Gnt
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mstrobe_q, mstrobe_d;
  logic          mrw_q, mrw_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] mwdata_q, mwdata_d;
  logic [1:0]    cready_q, cready_d;
  logic [1:0]    cerr_q, cerr_d;
  logic [DW-1:0] crdata0_q, crdata0_d;
  logic [DW-1:0] crdata1_q, crdata1_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;  // port 0 wins the first tie
      cnt_q     <= '0;
      mstrobe_q <= 1'b0;
      mrw_q     <= 1'b1;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      cready_q  <= 2'b00;
      cerr_q    <= 2'b00;
      crdata0_q <= '0;
      crdata1_q <= '0;
      gnt_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      mstrobe_q <= mstrobe_d;
      mrw_q     <= mrw_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      cready_q  <= cready_d;
      cerr_q    <= cerr_d;
      crdata0_q <= crdata0_d;
      crdata1_q <= crdata1_d;
      gnt_q     <= gnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    mstrobe_d = mstrobe_q;
    mrw_d     = mrw_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    cready_d  = cready_q;
    cerr_d    = cerr_q;
    crdata0_d = crdata0_q;
    crdata1_d = crdata1_q;
    gnt_d     = gnt_q;
    sel       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (CStrobe0 || CStrobe1) begin
          // On a tie the port not served last goes next, so neither can starve the other.
          sel       = (CStrobe0 && CStrobe1) ? ~last_q : CStrobe1;
          owner_d   = sel;
          mrw_d     = sel ? CRW1 : CRW0;
          maddr_d   = sel ? CAddress1 : CAddress0;
          mwdata_d  = sel ? CWData1 : CWData0;
          mstrobe_d = 1'b1;
          gnt_d     = sel ? 2'b10 : 2'b01;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // MReady takes priority over a timeout on the same cycle.
        if (MReady) begin
          mstrobe_d         = 1'b0;
          cready_d[owner_q] = 1'b1;
          cerr_d[owner_q]   = 1'b0;
          if (mrw_q) begin
            if (owner_q) crdata1_d = MRData;
            else         crdata0_d = MRData;
          end
          last_d  = owner_q;
          state_d = StDone;
        end else if (cnt_q == CntMax) begin
          mstrobe_d         = 1'b0;
          cready_d[owner_q] = 1'b1;
          cerr_d[owner_q]   = 1'b1;
          if (owner_q) crdata1_d = '0;
          else         crdata0_d = '0;
          last_d  = owner_q;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        cready_d = 2'b00;
        cerr_d   = 2'b00;
        gnt_d    = 2'b00;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign MStrobe  = mstrobe_q;
  assign MRW      = mrw_q;
  assign MAddress = maddr_q;
  assign MWData   = mwdata_q;
  assign CReady0  = cready_q[0];
  assign CReady1  = cready_q[1];
  assign CErr0    = cerr_q[0];
  assign CErr1    = cerr_q[1];
  assign CRData0  = crdata0_q;
  assign CRData1  = crdata1_q;
  assign Gnt      = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single transactions, hand-written
// reset / tie / rotation / stray-MReady sequences, and a completion scoreboard.
module tb_mem_port_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 64;

  logic          clk;
  logic          reset;
  logic [1:0]    cstb;
  logic [1:0]    crw;
  logic [31:0]   req_addr  [2];
  logic [31:0]   req_wdata [2];
  logic          CReady0, CReady1, CErr0, CErr1;
  logic [31:0]   CRData0, CRData1;
  logic          MStrobe, MRW, MReady;
  logic [31:0]   MAddress, MWData, MRData;
  logic [1:0]    Gnt;

  mem_port_arbiter #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .CStrobe0  (cstb[0]),
    .CRW0      (crw[0]),
    .CAddress0 (req_addr[0]),
    .CWData0   (req_wdata[0]),
    .CReady0   (CReady0),
    .CRData0   (CRData0),
    .CErr0     (CErr0),
    .CStrobe1  (cstb[1]),
    .CRW1      (crw[1]),
    .CAddress1 (req_addr[1]),
    .CWData1   (req_wdata[1]),
    .CReady1   (CReady1),
    .CRData1   (CRData1),
    .CErr1     (CErr1),
    .MStrobe   (MStrobe),
    .MRW       (MRW),
    .MAddress  (MAddress),
    .MWData    (MWData),
    .MRData    (MRData),
    .MReady    (MReady),
    .Gnt       (Gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] crd_model [2];

  typedef struct {
    int          port;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;    // BUSY cycle in which MReady is pulsed; 0 = never
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Completion scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (CReady0 || CReady1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_cready", {62'd0, CReady1, CReady0}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_both_ready", {63'd0, CReady0 && CReady1}, 64'd0);
        chk("sb_port", {63'd0, CReady1}, 64'(e.port));
        chk("sb_rdata", {32'd0, CReady1 ? CRData1 : CRData0}, {32'd0, e.rdata});
        chk("sb_err", {63'd0, CReady1 ? CErr1 : CErr0}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic request(input int p, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata);
    crw[p]       = rw;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
    cstb[p]      = 1'b1;
  endtask

  // Called at a negedge; waits for port p to be granted, plays memory, checks completion.
  task automatic serve(input int p, input int rdy, input logic [31:0] rdata);
    int   cyc;
    int   lat;
    int   exp_lat;
    bit   got;
    bit   tout;
    exp_t e;
    cyc = 0;
    while (Gnt == 2'b00 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("gnt_wait", 64'(cyc), 64'd1);
    chk("gnt", {62'd0, Gnt}, (p == 0) ? 64'd1 : 64'd2);
    chk("mstrobe_up", {63'd0, MStrobe}, 64'd1);
    chk("mrw", {63'd0, MRW}, {63'd0, crw[p]});
    chk("maddr", {32'd0, MAddress}, {32'd0, req_addr[p]});
    if (!crw[p]) chk("mwdata", {32'd0, MWData}, {32'd0, req_wdata[p]});

    tout    = !(rdy >= 1 && rdy <= int'(TIMEOUT));
    exp_lat = tout ? int'(TIMEOUT) : rdy;
    e.port  = p;
    e.err   = tout;
    if (tout)        e.rdata = 32'd0;
    else if (crw[p]) e.rdata = rdata;
    else             e.rdata = crd_model[p];
    crd_model[p] = e.rdata;
    sb.push_back(e);

    cyc = 1;
    got = 0;
    lat = 0;
    while (!got && cyc <= int'(TIMEOUT) + 4) begin
      MReady = (cyc == rdy);
      MRData = (cyc == rdy) ? rdata : $urandom();
      @(negedge clk);
      if (CReady0 || CReady1) begin
        got = 1;
        lat = cyc;
      end else begin
        if (!crw[p]) chk("mwdata_held", {32'd0, MWData}, {32'd0, req_wdata[p]});
        cyc++;
      end
    end
    MReady = 1'b0;
    chk("cready_seen", {63'd0, got}, 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("mstrobe_down", {63'd0, MStrobe}, 64'd0);
    cstb[p] = 1'b0;
    @(negedge clk);
    chk("done_clear", {61'd0, Gnt, CReady1 | CReady0}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, 1'b1, 32'h0000_1004, 32'h0,         3,       32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b0, 32'h0000_2008, 32'h1234_5678, 2,       32'hFFFF_FFFF};
    vecs[2] = '{0, 1'b0, 32'h0000_3000, 32'hAAAA_5555, 1,       32'h1111_1111};
    vecs[3] = '{1, 1'b1, 32'h0000_2010, 32'h0,         5,       32'hCAFE_F00D};
    vecs[4] = '{0, 1'b1, 32'h0000_1008, 32'h0,         0,       32'h2222_2222};
    vecs[5] = '{0, 1'b1, 32'h0000_100C, 32'h0,         1,       32'h0BAD_F00D};
    vecs[6] = '{1, 1'b1, 32'h0000_4000, 32'h0,         TIMEOUT, 32'h55AA_55AA};
    vecs[7] = '{1, 1'b0, 32'h0000_4004, 32'h7777_8888, 0,       32'h3333_3333};

    reset  = 1'b0;
    cstb   = 2'b00;
    crw    = 2'b11;
    req_addr[0] = '0; req_addr[1] = '0;
    req_wdata[0] = '0; req_wdata[1] = '0;
    MReady = 1'b0;
    MRData = '0;
    crd_model[0] = '0; crd_model[1] = '0;

    // Reset values
    @(negedge clk);
    chk("rst_mstrobe", {63'd0, MStrobe}, 64'd0);
    chk("rst_mrw", {63'd0, MRW}, 64'd1);
    chk("rst_maddr", {32'd0, MAddress}, 64'd0);
    chk("rst_mwdata", {32'd0, MWData}, 64'd0);
    chk("rst_cready", {62'd0, CReady1, CReady0}, 64'd0);
    chk("rst_cerr", {62'd0, CErr1, CErr0}, 64'd0);
    chk("rst_crdata", {CRData1, CRData0}, 64'd0);
    chk("rst_gnt", {62'd0, Gnt}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      request(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      serve(vecs[i].port, vecs[i].rdy, vecs[i].rdata);
      chk("other_cready_idle", {62'd0, CReady1, CReady0}, 64'd0);
    end

    // Stray MReady while idle is ignored
    MReady = 1'b1;
    MRData = 32'hFEED_FACE;
    @(negedge clk);
    MReady = 1'b0;
    @(negedge clk);
    chk("stray_cready", {62'd0, CReady1, CReady0}, 64'd0);
    chk("stray_gnt", {62'd0, Gnt}, 64'd0);
    chk("stray_crdata1", {32'd0, CRData1}, {32'd0, crd_model[1]});

    // Reset in the middle of BUSY drops the transaction immediately
    request(0, 1'b1, 32'h0000_5000, 32'h0);
    @(negedge clk);
    chk("midrst_gnt_before", {62'd0, Gnt}, 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_mstrobe", {63'd0, MStrobe}, 64'd0);
    chk("midrst_gnt", {62'd0, Gnt}, 64'd0);
    chk("midrst_cready", {62'd0, CReady1, CReady0}, 64'd0);
    crd_model[0] = '0; crd_model[1] = '0;

    // Both strobes high out of reset: port 0 first, then strict alternation
    request(0, 1'b1, 32'h0000_6000, 32'h0);
    request(1, 1'b0, 32'h0000_7000, 32'hA5A5_0001);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int p;
      p = i % 2;
      serve(p, 1 + (i % 3), 32'h1000_0000 + 32'(i));
      if (i < 4) request(p, ~crw[p], req_addr[p] + 32'h4, req_wdata[p] + 32'h1);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
